// File: rtl/ram_bus_arbiter.sv
// Two-master RAM bus arbiter: round-robin grant with a hold-time watchdog,
// RAM turnaround wait and a mandatory one-cycle guard between grants.
module ram_bus_arbiter #(
    parameter int MAX_HOLD = 64
) (
    input  logic       clk,
    input  logic       rst_a,
    input  logic [1:0] req,
    input  logic [1:0] done,
    input  logic       dly,
    output logic [1:0] gnt,
    output logic       owner,
    output logic       busy,
    output logic       timeout_evt,
    output logic [7:0] timeout_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BBUSY = 2'd1,
        BWAIT = 2'd2,
        BFREE = 2'd3
    } state_t;

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    state_t     state_r;
    state_t     state_s;
    logic       owner_r;
    logic       owner_s;
    logic [7:0] hold_r;
    logic [7:0] hold_s;
    logic       evt_r;
    logic       evt_s;
    logic [7:0] tcnt_r;
    logic [7:0] tcnt_s;
    logic [1:0] gnt_r;
    logic       busy_r;
    logic       done_own_s;

    // With both requests pending the non-owner wins; otherwise the lone requester.
    function automatic logic pick_winner(input logic [1:0] r, input logic last_owner);
        logic w;
        if (r == 2'b11) begin
            w = ~last_owner;
        end else begin
            w = r[1];
        end
        return w;
    endfunction

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        logic [7:0] n;
        if (v == 8'd255) begin
            n = v;
        end else begin
            n = v + 8'd1;
        end
        return n;
    endfunction

    // Grant is decoded from the upcoming state and owner so it comes straight off a flop.
    function automatic logic [1:0] grant_decode(input state_t st, input logic own);
        logic [1:0] g;
        if ((st == BBUSY) || (st == BWAIT)) begin
            g = own ? 2'b10 : 2'b01;
        end else begin
            g = 2'b00;
        end
        return g;
    endfunction

    assign done_own_s = done[owner_r];

    // Next-state, owner, watchdog and timeout statistics.
    always_comb begin
        state_s = state_r;
        owner_s = owner_r;
        hold_s  = hold_r;
        evt_s   = 1'b0;
        tcnt_s  = tcnt_r;
        case (state_r)
            IDLE, BFREE: begin
                if (req != 2'b00) begin
                    state_s = BBUSY;
                    owner_s = pick_winner(req, owner_r);
                    hold_s  = 8'd0;
                end else begin
                    state_s = IDLE;
                end
            end
            BBUSY: begin
                hold_s = hold_r + 8'd1;
                if (done_own_s) begin
                    state_s = dly ? BWAIT : BFREE;
                end else if (hold_r == HOLD_LAST) begin
                    // A done in the same cycle takes priority and is not a timeout.
                    state_s = dly ? BWAIT : BFREE;
                    evt_s   = 1'b1;
                    tcnt_s  = sat_inc(tcnt_r);
                end else begin
                    state_s = BBUSY;
                end
            end
            BWAIT: begin
                if (dly) begin
                    state_s = BWAIT;
                end else begin
                    state_s = BFREE;
                end
            end
            default: begin
                state_s = IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst_a) begin
            state_r <= IDLE;
            owner_r <= 1'b1;
            hold_r  <= 8'd0;
            evt_r   <= 1'b0;
            tcnt_r  <= 8'd0;
            gnt_r   <= 2'b00;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            owner_r <= owner_s;
            hold_r  <= hold_s;
            evt_r   <= evt_s;
            tcnt_r  <= tcnt_s;
            gnt_r   <= grant_decode(state_s, owner_s);
            busy_r  <= (state_s == BBUSY) || (state_s == BWAIT);
        end
    end

    assign gnt         = gnt_r;
    assign owner       = owner_r;
    assign busy        = busy_r;
    assign timeout_evt = evt_r;
    assign timeout_cnt = tcnt_r;

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Self-checking bench for ram_bus_arbiter: directed scenarios plus random
// traffic, all checked every cycle against a transaction-level model.
module tb_ram_bus_arbiter;

    localparam int MAXH = 4;

    logic       clk = 1'b0;
    logic       rst_a;
    logic [1:0] req;
    logic [1:0] done;
    logic       dly;
    logic [1:0] gnt;
    logic       owner;
    logic       busy;
    logic       timeout_evt;
    logic [7:0] timeout_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Model: is the bus granted, is it in RAM turnaround, who owns it,
    // how many cycles the current grant has run, and timeout statistics.
    bit m_granted;
    bit m_turn;
    bit m_owner;
    bit m_evt;
    int m_hold;
    int m_tcnt;

    ram_bus_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk(clk), .rst_a(rst_a), .req(req), .done(done), .dly(dly),
        .gnt(gnt), .owner(owner), .busy(busy),
        .timeout_evt(timeout_evt), .timeout_cnt(timeout_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step();
        m_evt = 1'b0;
        if (rst_a) begin
            m_granted = 1'b0; m_turn = 1'b0; m_owner = 1'b1; m_hold = 0; m_tcnt = 0;
        end else if (!m_granted) begin
            if (req != 2'b00) begin
                m_owner   = (req == 2'b11) ? !m_owner : req[1];
                m_granted = 1'b1;
                m_turn    = 1'b0;
                m_hold    = 0;
            end
        end else if (m_turn) begin
            if (!dly) begin
                m_granted = 1'b0; m_turn = 1'b0;
            end
        end else begin
            m_hold++;
            if (done[m_owner] || m_hold == MAXH) begin
                if (!done[m_owner]) begin
                    m_evt = 1'b1;
                    if (m_tcnt < 255) m_tcnt++;
                end
                if (dly) m_turn = 1'b1;
                else m_granted = 1'b0;
            end
        end
    endtask

    task automatic model_compare();
        int exp_gnt;
        exp_gnt = m_granted ? (m_owner ? 2 : 1) : 0;
        chk("gnt", int'(gnt), exp_gnt);
        chk("owner", int'(owner), int'(m_owner));
        chk("busy", int'(busy), int'(m_granted));
        chk("timeout_evt", int'(timeout_evt), int'(m_evt));
        chk("timeout_cnt", int'(timeout_cnt), m_tcnt);
    endtask

    // Drive one cycle of inputs (called at negedge), step model at the edge, compare at next negedge.
    task automatic cyc(input logic r, input logic [1:0] q, input logic [1:0] d, input logic y);
        rst_a = r; req = q; done = d; dly = y;
        @(posedge clk);
        model_step();
        @(negedge clk);
        model_compare();
    endtask

    task automatic do_reset();
        for (int i = 0; i < 2; i++) cyc(1'b1, 2'b11, 2'b11, 1'b1);
    endtask

    initial begin
        int seq[6];
        int ngrant;
        int nevt;
        rst_a = 1'b1; req = 2'b00; done = 2'b00; dly = 1'b0;
        @(negedge clk);

        // Reset state, with req held high during reset.
        do_reset();
        chk("rst_gnt", int'(gnt), 0);
        chk("rst_owner", int'(owner), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_cnt", int'(timeout_cnt), 0);

        // Single request, req dropped while granted, done releases.
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        chk("t1_gnt_first", int'(gnt), 1);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        chk("t1_gnt_held", int'(gnt), 1);
        cyc(1'b0, 2'b00, 2'b01, 1'b0);
        chk("t1_bfree_gnt", int'(gnt), 0);
        chk("t1_bfree_busy", int'(busy), 0);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        chk("t1_idle_gnt", int'(gnt), 0);
        chk("t1_owner", int'(owner), 0);

        // Both requesting: grants alternate with one guard cycle between them.
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(1'b0, 2'b11, 2'b11, 1'b0);
            seq[i] = int'(gnt);
        end
        chk("t2_g0", seq[0], 1); chk("t2_g1", seq[1], 0);
        chk("t2_g2", seq[2], 2); chk("t2_g3", seq[3], 0);
        chk("t2_g4", seq[4], 1); chk("t2_g5", seq[5], 0);

        // Watchdog: requester 1 never signals done.
        do_reset();
        ngrant = 0;
        for (int i = 0; i < 4; i++) begin
            cyc(1'b0, 2'b10, 2'b00, 1'b0);
            if (gnt == 2'b10) ngrant++;
        end
        chk("t3_grant_len", ngrant, 4);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        chk("t3_gnt_off", int'(gnt), 0);
        chk("t3_evt", int'(timeout_evt), 1);
        chk("t3_cnt", int'(timeout_cnt), 1);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        chk("t3_evt_once", int'(timeout_evt), 0);

        // Turnaround wait, plus a non-owner done during the grant.
        do_reset();
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b10, 1'b0);
        chk("t4_nonowner_done", int'(gnt), 1);
        ngrant = 0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 2'b00, (i == 0) ? 2'b01 : 2'b00, 1'b1);
            if (gnt == 2'b01) ngrant++;
        end
        chk("t4_wait_len", ngrant, 3);
        cyc(1'b0, 2'b00, 2'b00, 1'b0);
        chk("t4_bfree", int'(gnt), 0);

        // Reset in the middle of a turnaround wait.
        cyc(1'b0, 2'b10, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b10, 1'b1);
        chk("t5_in_wait", int'(busy), 1);
        cyc(1'b1, 2'b00, 2'b00, 1'b1);
        chk("t5_rst_gnt", int'(gnt), 0);
        chk("t5_rst_busy", int'(busy), 0);
        cyc(1'b0, 2'b11, 2'b00, 1'b0);
        chk("t5_first_win", int'(gnt), 1);

        // Done arriving on the timeout cycle counts as a normal release.
        do_reset();
        cyc(1'b0, 2'b01, 2'b00, 1'b0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 2'b00, 2'b00, 1'b0);
        cyc(1'b0, 2'b00, 2'b01, 1'b0);
        chk("t6_coinc_gnt", int'(gnt), 0);
        chk("t6_coinc_evt", int'(timeout_evt), 0);
        chk("t6_coinc_cnt", int'(timeout_cnt), 0);

        // Saturation of the timeout counter.
        do_reset();
        nevt = 0;
        for (int i = 0; i < 260 * (MAXH + 1); i++) begin
            cyc(1'b0, 2'b01, 2'b00, 1'b0);
            if (timeout_evt) nevt++;
        end
        chk("t7_nevt", nevt, 260);
        chk("t7_sat", int'(timeout_cnt), 255);

        // Random traffic with occasional resets.
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 63) == 0) ? 1'b1 : 1'b0,
                2'($urandom_range(0, 3)),
                ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00,
                ($urandom_range(0, 1) == 0) ? 1'b1 : 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
